// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader's view. The master modport is the view of
// the byte source and of the memory/CPU side.
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, load_done, load_error
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a framed byte image and writes 16-bit words into
// instruction memory starting at word 0. The CPU is held in reset until
// the image has loaded and its XOR checksum matches.
//
// Frame: count_hi count_lo | {hi lo} x count | checksum
// The checksum is the XOR of every byte that comes before it.
//
// state   | meaning
// CNT_HI  | waiting for the high byte of the word count
// CNT_LO  | waiting for the low byte of the count; the count is range-checked here
// DATA_HI | waiting for the high byte of the next word
// DATA_LO | waiting for the low byte of the next word
// WRITE   | one-cycle write strobe to memory; no byte is accepted
// CHECK   | waiting for the checksum byte
// DONE    | image verified and CPU released; stays here until reset
// ERROR   | bad count or checksum; CPU stays held; stays here until reset
module imem_loader #(
  parameter int ADDR_W = 9
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  // Largest legal count is the full memory depth.
  localparam logic [16:0] MAX_COUNT = 17'(1) << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;

  logic              in_ready;
  logic              imem_we;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic              xfer;
  logic [15:0]       count_full;
  logic              count_bad;
  logic              last_word;

  assign xfer       = bus.in_valid & in_ready;
  assign count_full = {count[15:8], bus.in_data};
  assign count_bad  = (count_full == 16'd0) || ({1'b0, count_full} > MAX_COUNT);
  // A count of 0 is rejected before WRITE, so count - 1 cannot underflow here.
  assign last_word  = (16'(addr) == count - 16'd1);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CNT_HI;
    else       state <= state_nxt;
  end

  // Next state, and outputs decoded only from the registered state.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      CNT_HI: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = count_bad ? ERROR : DATA_HI;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        imem_we   = 1'b1;
        state_nxt = last_word ? CHECK : DATA_HI;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
      end
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      ERROR: begin
        load_error = 1'b1;
      end
      default: state_nxt = CNT_HI;
    endcase
  end

  // Datapath: capture the count and word bytes, keep the running checksum,
  // and advance the word address after each write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      csum  <= '0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      case (state)
        CNT_HI: if (xfer) begin
          count[15:8] <= bus.in_data;
          csum        <= csum ^ bus.in_data;
        end
        CNT_LO: if (xfer) begin
          count[7:0] <= bus.in_data;
          csum       <= csum ^ bus.in_data;
          addr       <= '0;
        end
        DATA_HI: if (xfer) begin
          wdata[15:8] <= bus.in_data;
          csum        <= csum ^ bus.in_data;
        end
        DATA_LO: if (xfer) begin
          wdata[7:0] <= bus.in_data;
          csum       <= csum ^ bus.in_data;
        end
        // The address stops on the last word, so it never wraps.
        WRITE: if (!last_word) addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.load_done  = load_done;
  assign bus.load_error = load_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of frames with expected writes and
// final status, plus hand-written capacity and mid-load reset sequences.
module tb_imem_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;

  imem_loader_if #(.ADDR_W(9)) bus ();

  imem_loader #(.ADDR_W(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]         nbytes;
    logic [0:19][7:0]   bytes;
    logic [7:0]         nwr;
    logic [0:7][15:0]   words;
    logic               exp_done;
    logic               exp_err;
    logic               stall;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int fails  = 0;

  logic [8:0]  aq [$];
  logic [15:0] dq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record each memory write, and check that no byte is offered as accepted during it.
  always @(negedge clock) begin
    if (!reset && bus.imem_we) begin
      aq.push_back(bus.imem_addr);
      dq.push_back(bus.imem_wdata);
      chk("in_ready_low_in_write", 32'(bus.in_ready), 32'd0);
    end
  end

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    aq.delete();
    dq.delete();
  endtask

  // Starts and ends at a negedge; returns in the cycle after the byte transfers.
  task automatic send_byte(input logic [7:0] b, input logic stall);
    int   n;
    int   guard;
    logic rdy;
    if (stall) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clock);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    forever begin
      rdy = bus.in_ready;
      @(posedge clock);
      @(negedge clock);
      if (rdy) break;
      guard++;
      if (guard > 20) begin
        chk("byte_accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
  endtask

  task automatic check_final(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, "_load_done"}, 32'(bus.load_done), 32'(exp_done));
    chk({tag, "_load_error"}, 32'(bus.load_error), 32'(exp_err));
    chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
    chk({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
    chk({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:19][7:0] ref_bytes;
    logic [0:7][15:0] ref_words;
    logic [7:0]       cs;
    logic [15:0]      w;
    int               nw;

    ref_bytes = {8'h00, 8'h08, 8'h41, 8'h0F, 8'h42, 8'h07, 8'h29, 8'hC0, 8'h17, 8'h80,
                 8'h3E, 8'h80, 8'h0B, 8'hC0, 8'h7B, 8'h40, 8'h7E, 8'h40, 8'h0D, 8'h00};
    ref_words = {16'h410F, 16'h4207, 16'h29C0, 16'h1780,
                 16'h3E80, 16'h0BC0, 16'h7B40, 16'h7E40};

    vecs[0] = '{nbytes: 8'd19, bytes: ref_bytes, nwr: 8'd8, words: ref_words,
                exp_done: 1'b1, exp_err: 1'b0, stall: 1'b0};
    vecs[1] = vecs[0];
    vecs[1].bytes[18] = 8'h0C;
    vecs[1].exp_done  = 1'b0;
    vecs[1].exp_err   = 1'b1;
    vecs[2] = '{nbytes: 8'd2, bytes: '0, nwr: 8'd0, words: '0,
                exp_done: 1'b0, exp_err: 1'b1, stall: 1'b0};
    vecs[3] = vecs[2];
    vecs[3].bytes[0] = 8'h02;
    vecs[3].bytes[1] = 8'h01;
    vecs[4] = '{nbytes: 8'd5, bytes: '0, nwr: 8'd1, words: '0,
                exp_done: 1'b1, exp_err: 1'b0, stall: 1'b1};
    vecs[4].bytes[0] = 8'h00;
    vecs[4].bytes[1] = 8'h01;
    vecs[4].bytes[2] = 8'hAB;
    vecs[4].bytes[3] = 8'hCD;
    vecs[4].bytes[4] = 8'h67;
    vecs[4].words[0] = 16'hABCD;
    vecs[5] = vecs[0];
    vecs[5].stall = 1'b1;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    check_reset_vals("reset_initial");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int j = 0; j < int'(vecs[v].nbytes); j++)
        send_byte(vecs[v].bytes[j], vecs[v].stall);
      check_final($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      // Terminal states must ignore further bytes.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      repeat (4) begin
        @(negedge clock);
        chk($sformatf("vec%0d_terminal_ready", v), 32'(bus.in_ready), 32'd0);
        chk($sformatf("vec%0d_terminal_done", v), 32'(bus.load_done), 32'(vecs[v].exp_done));
      end
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_nwrites", v), 32'(aq.size()), 32'(vecs[v].nwr));
      for (int k = 0; k < int'(vecs[v].nwr) && k < aq.size(); k++) begin
        chk($sformatf("vec%0d_addr%0d", v, k), 32'(aq[k]), 32'(k));
        chk($sformatf("vec%0d_data%0d", v, k), 32'(dq[k]), 32'(vecs[v].words[k]));
      end
    end

    // Capacity boundary: 512 words whose value equals their index.
    do_reset();
    cs = 8'h02 ^ 8'h00;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 512; i++) begin
      w = 16'(i);
      cs = cs ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
    end
    send_byte(cs, 1'b0);
    check_final("cap", 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    bus.in_valid = 1'b0;
    chk("cap_nwrites", 32'(aq.size()), 32'd512);
    nw = 0;
    for (int k = 0; k < aq.size(); k++)
      if (aq[k] !== 9'(k) || dq[k] !== 16'(k)) nw++;
    chk("cap_bad_entries", 32'(nw), 32'd0);
    if (aq.size() > 0) begin
      chk("cap_last_addr", 32'(aq[aq.size()-1]), 32'd511);
      chk("cap_last_data", 32'(dq[dq.size()-1]), 32'h01FF);
    end
    chk("cap_final_addr", 32'(bus.imem_addr), 32'd511);

    // Async reset between the hi and lo bytes of word 3.
    do_reset();
    for (int j = 0; j < 9; j++) send_byte(ref_bytes[j], 1'b0);
    bus.in_valid = 1'b0;
    chk("midrst_pre_addr", 32'(bus.imem_addr), 32'd3);
    chk("midrst_pre_wdata_hi", 32'(bus.imem_wdata[15:8]), 32'h17);
    chk("midrst_pre_nwrites", 32'(aq.size()), 32'd3);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b0;
    aq.delete();
    dq.delete();
    for (int j = 0; j < 19; j++) send_byte(ref_bytes[j], 1'b0);
    check_final("midrst_reload", 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("midrst_nwrites", 32'(aq.size()), 32'd8);
    for (int k = 0; k < 8 && k < aq.size(); k++) begin
      chk($sformatf("midrst_addr%0d", k), 32'(aq[k]), 32'(k));
      chk($sformatf("midrst_data%0d", k), 32'(dq[k]), 32'(ref_words[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
